vending_machine_gen: RTL and testbench
======================================

# vending_machine_gen

Parametrised successor of the fixed-price soda vending FSM. It accepts nickel, dime and quarter inserts into a saturating credit counter with a configurable price. It tracks product stock and supports cancel/refund. Change goes out one nickel at a time over a valid/ready handshake to the coin-return mechanism. It sits between the coin acceptor front-end and the dispenser/coin-return actuators.

## Interface
- `PRICE`, default 4: product price in nickel units (4 = 20 c); legal range 1 .. 2^CREDIT_W-1.
- `CREDIT_W`, default 6: credit counter width in nickel units.
- `STOCK_W`, default 4: stock counter width.
- `STOCK_INIT`, default 10: stock value loaded at reset and on restock; must be ≤ 2^STOCK_W-1.

Ports:
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_ni` in 1: synchronous, active-low reset.
- `nickle_i` in 1: 5 c coin present this cycle (1 unit).
- `dime_i` in 1: 10 c coin present this cycle (2 units).
- `quarter_i` in 1: 25 c coin present this cycle (5 units).
- `cancel_i` in 1: refund request.
- `restock_i` in 1: reload stock to STOCK_INIT.
- `change_ready_i` in 1: coin return accepts one nickel.
- `soda_o` out 1: one-cycle dispense pulse.
- `change_valid_o` out 1: one nickel of change offered.
- `coin_reject_o` out 1: one-cycle pulse, the coin sampled this edge was not credited.
- `credit_o` out CREDIT_W: current credit in nickel units.
- `stock_o` out STOCK_W: remaining stock.
- `sold_out_o` out 1: stock_o == 0.
- `busy_o` out 1: FSM in VEND or CHANGE.

## Operation
- States:
  - COLLECT: accepts coins.
  - VEND: dispense cycle.
  - CHANGE: paying out credit.
- Coin sample: exactly one of nickle_i/dime_i/quarter_i high is a valid coin. Two or more high is an invalid coin: rejected, credit unchanged.
- COLLECT:
  - Cancel with credit > 0 → CHANGE. Any coin in the same cycle is rejected. Cancel with credit 0 is ignored.
  - Otherwise, a valid coin is credited only if the stock is non-zero and credit+value ≤ 2^CREDIT_W-1. Else coin_reject_o pulses.
  - Credited and new credit ≥ PRICE → VEND.
- VEND (exactly one cycle):
  - soda_o=1, credit −= PRICE, stock −= 1.
  - Next state is CHANGE if the remainder > 0, else COLLECT.
- CHANGE:
  - change_valid_o=1 held while credit > 0.
  - Each cycle with change_valid_o && change_ready_i: credit −= 1.
  - The last accepted nickel → COLLECT.
  - change_valid_o never drops without a handshake.
- Coins in VEND or CHANGE are always rejected. Cancel in VEND or CHANGE is ignored.
- restock_i: stock ← STOCK_INIT in any state. It has priority over the VEND decrement in the same cycle.
- Arithmetic: credit and stock are unsigned. Credit never wraps (guarded above). Stock is never decremented at 0, because coins are rejected when sold out.

## Timing
- All outputs are registered.
- Reset values: state COLLECT, credit_o=0, stock_o=STOCK_INIT, sold_out_o=(STOCK_INIT==0), soda_o=0, change_valid_o=0, coin_reject_o=0, busy_o=0.
- Coin sampled at edge N:
  - credit_o updated after edge N; coin_reject_o high during cycle N+1 if rejected.
  - If the price is reached, soda_o is high in cycle N+1.
  - credit_o and stock_o are reduced after edge N+1.
  - change_valid_o is first high in cycle N+2.
- Cancel at edge N: change_valid_o high from cycle N+1.
- Change throughput: one nickel per cycle with ready held high.
- Minimum back-to-back vend spacing: 2 cycles with no change.
- Reset mid-operation discards credit and any pending change; stock reloads to STOCK_INIT.

## Test plan
- Defaults, reset, quarter at cycle 1:
  - soda_o pulse in cycle 2.
  - One change handshake with ready=1, credit_o 5→1→0, stock_o 10→9.
- Nickel, dime, nickel on consecutive cycles:
  - credit_o 1,3,4, then soda_o.
  - credit_o=0, no change_valid_o.
- Dime then cancel with change_ready_i toggling 0,1,0,1:
  - change_valid_o stays high until 2 handshakes complete.
  - credit_o 2→1→0, no soda_o.
  - A quarter during CHANGE pulses coin_reject_o.
- STOCK_INIT=1: quarter vends, sold_out_o=1.
  - Next dime is rejected with credit unchanged.
  - restock_i → stock_o=1, sold_out_o=0, dime accepted.
- nickle_i and dime_i together → coin_reject_o, credit unchanged.
  - CREDIT_W=3: credit 3, quarter → rejected (3+5>7).
- Reset asserted mid-CHANGE with credit 3:
  - Next cycle all outputs at reset values, change_valid_o=0.

Source files
------------

// File: rtl/vending_machine_gen.sv
// Parametrised vending controller: nickel/dime/quarter credit, stock tracking,
// cancel/refund, and change paid out one nickel at a time over valid/ready.
module vending_machine_gen #(
  parameter int unsigned PRICE      = 4,
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                nickle_i,
  input  logic                dime_i,
  input  logic                quarter_i,
  input  logic                cancel_i,
  input  logic                restock_i,
  input  logic                change_ready_i,
  output logic                soda_o,
  output logic                change_valid_o,
  output logic                coin_reject_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [STOCK_W-1:0]  stock_o,
  output logic                sold_out_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_e;

  // Three spare bits so credit plus the largest coin never wraps before the limit check.
  localparam int unsigned          SUM_W      = CREDIT_W + 3;
  localparam logic [SUM_W-1:0]     CREDIT_MAX = {3'b000, {CREDIT_W{1'b1}}};
  localparam logic [SUM_W-1:0]     PRICE_S    = SUM_W'(PRICE);
  localparam logic [CREDIT_W-1:0]  PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [STOCK_W-1:0]   STOCK_RST  = STOCK_W'(STOCK_INIT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q, stock_d;
  logic                soda_q, soda_d;
  logic                change_valid_q, change_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sold_out_q, sold_out_d;
  logic                busy_q, busy_d;

  logic [1:0]          coin_cnt;
  logic                coin_any;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    credit_sum;
  logic                vend_dec;

  always_comb begin
    coin_cnt       = 2'(nickle_i) + 2'(dime_i) + 2'(quarter_i);
    coin_any       = nickle_i | dime_i | quarter_i;
    coin_val       = quarter_i ? SUM_W'(5) : (dime_i ? SUM_W'(2) : SUM_W'(1));
    credit_sum     = {3'b000, credit_q} + coin_val;
    state_d        = state_q;
    credit_d       = credit_q;
    soda_d         = 1'b0;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    vend_dec       = 1'b0;

    case (state_q)
      COLLECT: begin
        if (cancel_i && (credit_q != '0)) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          coin_reject_d  = coin_any;
        end else if (coin_any) begin
          if ((coin_cnt == 2'd1) && (stock_q != '0) && (credit_sum <= CREDIT_MAX)) begin
            credit_d = credit_sum[CREDIT_W-1:0];
            if (credit_sum >= PRICE_S) begin
              state_d = VEND;
              soda_d  = 1'b1;
            end
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      VEND: begin
        credit_d      = credit_q - PRICE_C;
        vend_dec      = 1'b1;
        coin_reject_d = coin_any;
        if (credit_d != '0) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      CHANGE: begin
        coin_reject_d  = coin_any;
        change_valid_d = 1'b1;
        if (change_valid_q && change_ready_i) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            state_d        = COLLECT;
            change_valid_d = 1'b0;
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    // Restock wins over the dispense decrement landing in the same cycle.
    if (restock_i)     stock_d = STOCK_RST;
    else if (vend_dec) stock_d = stock_q - STOCK_W'(1);
    else               stock_d = stock_q;

    sold_out_d = (stock_d == '0);
    busy_d     = (state_d != COLLECT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= COLLECT;
      credit_q       <= '0;
      stock_q        <= STOCK_RST;
      soda_q         <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sold_out_q     <= (STOCK_RST == '0);
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      stock_q        <= stock_d;
      soda_q         <= soda_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      sold_out_q     <= sold_out_d;
      busy_q         <= busy_d;
    end
  end

  assign soda_o         = soda_q;
  assign change_valid_o = change_valid_q;
  assign coin_reject_o  = coin_reject_q;
  assign credit_o       = credit_q;
  assign stock_o        = stock_q;
  assign sold_out_o     = sold_out_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed bench for vending_machine_gen: three parameterisations share one
// stimulus stream; each step queues the expected outputs of one instance.
module tb_vending_machine_gen;

  logic clk = 1'b0;
  logic rst_n, nk, dm, qt, cn, rs, rdy;

  logic       soda0, cv0, rej0, so0, bz0;
  logic [5:0] cr0;
  logic [3:0] st0;
  logic       soda1, cv1, rej1, so1, bz1;
  logic [5:0] cr1;
  logic [3:0] st1;
  logic       soda2, cv2, rej2, so2, bz2;
  logic [2:0] cr2;
  logic [3:0] st2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    dut;
    logic  soda, cv, rej, sold, busy;
    int    credit, stock;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  vending_machine_gen u0 (
    .clk_i(clk), .rst_ni(rst_n), .nickle_i(nk), .dime_i(dm), .quarter_i(qt),
    .cancel_i(cn), .restock_i(rs), .change_ready_i(rdy),
    .soda_o(soda0), .change_valid_o(cv0), .coin_reject_o(rej0),
    .credit_o(cr0), .stock_o(st0), .sold_out_o(so0), .busy_o(bz0));

  vending_machine_gen #(.STOCK_INIT(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .nickle_i(nk), .dime_i(dm), .quarter_i(qt),
    .cancel_i(cn), .restock_i(rs), .change_ready_i(rdy),
    .soda_o(soda1), .change_valid_o(cv1), .coin_reject_o(rej1),
    .credit_o(cr1), .stock_o(st1), .sold_out_o(so1), .busy_o(bz1));

  vending_machine_gen #(.CREDIT_W(3)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .nickle_i(nk), .dime_i(dm), .quarter_i(qt),
    .cancel_i(cn), .restock_i(rs), .change_ready_i(rdy),
    .soda_o(soda2), .change_valid_o(cv2), .coin_reject_o(rej2),
    .credit_o(cr2), .stock_o(st2), .sold_out_o(so2), .busy_o(bz2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drv(input logic n, d, q, c, r, rd);
    nk = n; dm = d; qt = q; cn = c; rs = r; rdy = rd;
  endtask

  // Queue the expectation, let one edge pass, then pop and compare.
  task automatic step(input string tag, input int dut, input logic soda, cv, rej,
                      input int credit, stock, input logic sold, busy);
    exp_t e, g;
    logic [31:0] o_soda, o_cv, o_rej, o_cr, o_st, o_so, o_bz;
    e.tag = tag; e.dut = dut; e.soda = soda; e.cv = cv; e.rej = rej;
    e.credit = credit; e.stock = stock; e.sold = sold; e.busy = busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    case (g.dut)
      1: begin
        o_soda = 32'(soda1); o_cv = 32'(cv1); o_rej = 32'(rej1);
        o_cr = 32'(cr1); o_st = 32'(st1); o_so = 32'(so1); o_bz = 32'(bz1);
      end
      2: begin
        o_soda = 32'(soda2); o_cv = 32'(cv2); o_rej = 32'(rej2);
        o_cr = 32'(cr2); o_st = 32'(st2); o_so = 32'(so2); o_bz = 32'(bz2);
      end
      default: begin
        o_soda = 32'(soda0); o_cv = 32'(cv0); o_rej = 32'(rej0);
        o_cr = 32'(cr0); o_st = 32'(st0); o_so = 32'(so0); o_bz = 32'(bz0);
      end
    endcase
    chk({g.tag, ".soda"},   o_soda, 32'(g.soda));
    chk({g.tag, ".cv"},     o_cv,   32'(g.cv));
    chk({g.tag, ".reject"}, o_rej,  32'(g.rej));
    chk({g.tag, ".credit"}, o_cr,   32'(g.credit));
    chk({g.tag, ".stock"},  o_st,   32'(g.stock));
    chk({g.tag, ".soldout"},o_so,   32'(g.sold));
    chk({g.tag, ".busy"},   o_bz,   32'(g.busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    //                       dut soda cv rej cr st sold busy
    step("rst_u0",            0, 0, 0, 0, 0, 10, 0, 0);
    rst_n = 1'b0;
    step("rst_u1",            1, 0, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;

    // Quarter: vend, one nickel of change.
    drv(0, 0, 1, 0, 0, 1);
    step("q_coin",            0, 1, 0, 0, 5, 10, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    step("q_vend",            0, 0, 1, 0, 1, 9, 0, 1);
    step("q_change",          0, 0, 0, 0, 0, 9, 0, 0);

    // Nickel, dime, nickel: exact price, no change.
    drv(1, 0, 0, 0, 0, 0);
    step("ndn_n1",            0, 0, 0, 0, 1, 9, 0, 0);
    drv(0, 1, 0, 0, 0, 0);
    step("ndn_d",             0, 0, 0, 0, 3, 9, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    step("ndn_n2",            0, 1, 0, 0, 4, 9, 0, 1);
    drv(0, 0, 0, 0, 0, 0);
    step("ndn_vend",          0, 0, 0, 0, 0, 8, 0, 0);

    // Dime, cancel, ready toggling; quarter during CHANGE is rejected.
    drv(0, 1, 0, 0, 0, 0);
    step("cx_dime",           0, 0, 0, 0, 2, 8, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    step("cx_cancel",         0, 0, 1, 0, 2, 8, 0, 1);
    drv(0, 0, 1, 0, 0, 0);
    step("cx_rdy0_q",         0, 0, 1, 1, 2, 8, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    step("cx_rdy1",           0, 0, 1, 0, 1, 8, 0, 1);
    drv(0, 0, 0, 0, 0, 0);
    step("cx_rdy0",           0, 0, 1, 0, 1, 8, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    step("cx_rdy1b",          0, 0, 0, 0, 0, 8, 0, 0);

    // STOCK_INIT=1 instance: sell out, reject, restock.
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 1);
    step("so_rst",            1, 0, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    drv(0, 0, 1, 0, 0, 1);
    step("so_quarter",        1, 1, 0, 0, 5, 1, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    step("so_vend",           1, 0, 1, 0, 1, 0, 1, 1);
    step("so_change",         1, 0, 0, 0, 0, 0, 1, 0);
    drv(0, 1, 0, 0, 0, 1);
    step("so_dime_rej",       1, 0, 0, 1, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 1, 1);
    step("so_restock",        1, 0, 0, 0, 0, 1, 0, 0);
    drv(0, 1, 0, 0, 0, 1);
    step("so_dime_ok",        1, 0, 0, 0, 2, 1, 0, 0);

    // Invalid coin combination, then CREDIT_W=3 overflow guard.
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step("inv_rst",           0, 0, 0, 0, 0, 10, 0, 0);
    rst_n = 1'b1;
    drv(1, 1, 0, 0, 0, 0);
    step("inv_nd",            0, 0, 0, 1, 0, 10, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    step("ov_n",              2, 0, 0, 0, 1, 10, 0, 0);
    drv(0, 1, 0, 0, 0, 0);
    step("ov_d",              2, 0, 0, 0, 3, 10, 0, 0);
    drv(0, 0, 1, 0, 0, 0);
    step("ov_q_rej",          2, 0, 0, 1, 3, 10, 0, 0);

    // Reset in the middle of paying out 3 nickels.
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step("mr_rst0",           0, 0, 0, 0, 0, 10, 0, 0);
    rst_n = 1'b1;
    drv(1, 0, 0, 0, 0, 0);
    step("mr_n",              0, 0, 0, 0, 1, 10, 0, 0);
    drv(0, 1, 0, 0, 0, 0);
    step("mr_d",              0, 0, 0, 0, 3, 10, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    step("mr_cancel",         0, 0, 1, 0, 3, 10, 0, 1);
    drv(0, 0, 0, 0, 0, 0);
    step("mr_hold",           0, 0, 1, 0, 3, 10, 0, 1);
    rst_n = 1'b0;
    step("mr_reset",          0, 0, 0, 0, 0, 10, 0, 0);
    rst_n = 1'b1;
    step("mr_idle",           0, 0, 0, 0, 0, 10, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
